// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU request/response sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 16;

  // Request opcodes. 7 and 9..15 are illegal.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_INS = 4'd6,
    OP_MUL = 4'd8
  } op_e;

  // ALU function select.
  typedef enum logic [2:0] {
    F_ADD = 3'd0,
    F_SUB = 3'd1,
    F_AND = 3'd2,
    F_OR  = 3'd3,
    F_SHL = 3'd4,
    F_SHR = 3'd5,
    F_INS = 3'd6,
    F_RSV = 3'd7
  } alu_f_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_e;

  // Opcode 7 and everything above MUL have no meaning.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op == 4'd7) || (op > 4'd8);
  endfunction

  // Only add and subtract report a carry.
  function automatic logic op_has_carry(input logic [3:0] op);
    return (op == 4'(OP_ADD)) || (op == 4'(OP_SUB));
  endfunction

endpackage

// File: rtl/alu.sv
// 16-bit single-cycle ALU: add, sub, and, or, shifts by y+1, field insert.
module alu
  import alu_seq_pkg::*;
(
  input  alu_f_e              f,
  input  logic [DATA_W-1:0]   x,
  input  logic [DATA_W-1:0]   y,
  output logic [DATA_W-1:0]   out,
  output logic                carry_out
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [DATA_W:0] sh_amt;

  // Pure combinational function select; shift amounts of 16 or more yield 0.
  always_comb begin
    sum       = {1'b0, x} + {1'b0, y};
    diff      = {1'b0, x} - {1'b0, y};
    sh_amt    = {1'b0, y} + 17'd1;
    out       = '0;
    carry_out = 1'b0;
    case (f)
      F_ADD: begin
        out       = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      F_SUB: begin
        out       = diff[DATA_W-1:0];
        carry_out = diff[DATA_W];
      end
      F_AND:   out = x & y;
      F_OR:    out = x | y;
      F_SHL:   out = x << sh_amt;
      F_SHR:   out = x >> sh_amt;
      F_INS:   out = {x[6:0], y[8:0]};
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready front end for the 16-bit ALU. Single-pass ops take one EXEC
// cycle; unsigned multiply runs MUL_STEPS add-and-shift passes through the
// same ALU.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// req_ready is high only in IDLE; rsp_valid is high only in RESP and the
// response fields hold steady until rsp_ready is seen. Both are state
// decodes with no combinational path from req_valid/rsp_ready.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_STEPS = 16
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [DATA_W-1:0] rsp_hi,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [3:0] LAST_STEP = 4'(MUL_STEPS - 1);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_lo_q, rsp_lo_d;
  logic [DATA_W-1:0] rsp_hi_q, rsp_hi_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_err_q, rsp_err_d;
  alu_f_e            alu_f_q, alu_f_d;
  logic [DATA_W-1:0] alu_x_q, alu_x_d;
  logic [DATA_W-1:0] alu_y_q, alu_y_d;

  logic [DATA_W-1:0] alu_out;
  logic              alu_co;
  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_mplr;

  alu u_alu (
    .f         (alu_f_d),
    .x         (alu_x_d),
    .y         (alu_y_d),
    .out       (alu_out),
    .carry_out (alu_co)
  );

  // One multiply step: shift the 17-bit partial sum right into acc_hi and
  // push its LSB into the top of the multiplier register.
  assign step_hi   = {alu_co, alu_out[DATA_W-1:1]};
  assign step_mplr = {alu_out[0], mplr_q[DATA_W-1:1]};

  // Next-state, datapath capture and ALU input steering. ALU inputs hold
  // their last applied values whenever the ALU result is not used.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_hi_d    = acc_hi_q;
    mplr_d      = mplr_q;
    cnt_d       = cnt_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    alu_f_d     = alu_f_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (req_op == 4'(OP_MUL)) begin
            acc_hi_d = '0;
            mplr_d   = req_b;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (!op_illegal(op_q)) begin
          alu_f_d = alu_f_e'(op_q[2:0]);
          alu_x_d = a_q;
          alu_y_d = b_q;
        end
        rsp_lo_d    = op_illegal(op_q) ? '0 : alu_out;
        rsp_hi_d    = '0;
        rsp_carry_d = op_has_carry(op_q) & alu_co;
        rsp_err_d   = op_illegal(op_q);
        state_d     = RESP;
      end
      MUL: begin
        alu_f_d  = F_ADD;
        alu_x_d  = acc_hi_q;
        alu_y_d  = mplr_q[0] ? a_q : '0;
        acc_hi_d = step_hi;
        mplr_d   = step_mplr;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) begin
          rsp_hi_d    = step_hi;
          rsp_lo_d    = step_mplr;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All sequencer state; asynchronous reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_f_q     <= F_ADD;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_hi_q    <= acc_hi_d;
      mplr_q      <= mplr_d;
      cnt_q       <= cnt_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      alu_f_q     <= alu_f_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q == EXEC) || (state_q == MUL);
  assign rsp_lo    = rsp_lo_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus randomized ops compared
// against an arithmetic reference model.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_lo;
  logic [15:0] rsp_hi;
  logic        rsp_carry;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sequencer #(.MUL_STEPS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {hi, lo, carry, err}.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] t;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        c;
    logic        e;
    int unsigned sh;
    lo = '0; hi = '0; c = 1'b0; e = 1'b0; t = '0;
    sh = 32'(b) + 32'd1;
    case (op)
      4'd0: begin t = 32'(a) + 32'(b); lo = t[15:0]; c = (t > 32'h0000_FFFF); end
      4'd1: begin t = 32'(a) - 32'(b); lo = t[15:0]; c = (a < b); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = (sh >= 16) ? 16'h0 : 16'(a << sh);
      4'd5: lo = (sh >= 16) ? 16'h0 : 16'(a >> sh);
      4'd6: begin t = (32'(a) << 9) | 32'(b & 16'h01FF); lo = t[15:0]; end
      4'd8: begin t = 32'(a) * 32'(b); lo = t[15:0]; hi = t[31:16]; end
      default: e = 1'b1;
    endcase
    return {hi, lo, c, e};
  endfunction

  // Driver: issue one op, measure latency, optionally stall, then take it.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, output logic [33:0] got, output int lat,
                        output logic stable_ok, output logic hs_ok);
    int waitc;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {rsp_hi, rsp_lo, rsp_carry, rsp_err};
    stable_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if ({rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_carry, rsp_err} !== {2'b10, got})
        stable_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    hs_ok = !rsp_valid && req_ready;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_carry, rsp_err, busy} !== {2'b10, 32'h0, 3'b000})
      $display("FAIL reset_outputs: got rdy=%b vld=%b lo=%h hi=%h c=%b e=%b busy=%b want rdy=1 rest 0",
               req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_carry, rsp_err, busy);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100)
      $display("FAIL reset_release: got rdy=%b busy=%b vld=%b want 1 0 0", req_ready, busy, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_add_carry();
    logic [33:0] got; int lat; logic st; logic hs;
    run_op(4'd0, 16'hFFFF, 16'h0001, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {16'h0000, 16'h0000, 1'b1, 1'b0})
      $display("FAIL add_carry: got %h want %h", got, {16'h0000, 16'h0000, 1'b1, 1'b0});
    else n_pass++;
    n_checks++;
    if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat);
    else n_pass++;
    n_checks++;
    if (hs !== 1'b1) $display("FAIL add_handshake: got %b want 1", hs);
    else n_pass++;
  endtask

  task automatic test_sub_shl();
    logic [33:0] got; int lat; logic st; logic hs;
    run_op(4'd1, 16'h0003, 16'h0005, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {16'h0000, 16'hFFFE, 1'b1, 1'b0})
      $display("FAIL sub_borrow: got %h want %h", got, {16'h0000, 16'hFFFE, 1'b1, 1'b0});
    else n_pass++;
    run_op(4'd4, 16'h0001, 16'h0003, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {16'h0000, 16'h0010, 1'b0, 1'b0})
      $display("FAIL shl: got %h want %h", got, {16'h0000, 16'h0010, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_mul();
    logic [33:0] got; int lat; logic st; logic hs;
    run_op(4'd8, 16'hFFFF, 16'hFFFF, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {16'hFFFE, 16'h0001, 1'b0, 1'b0})
      $display("FAIL mul_max: got %h want %h", got, {16'hFFFE, 16'h0001, 1'b0, 1'b0});
    else n_pass++;
    n_checks++;
    if (lat !== 16) $display("FAIL mul_latency: got %0d want 16", lat);
    else n_pass++;
    run_op(4'd8, 16'h1234, 16'h0000, 0, got, lat, st, hs);
    n_checks++;
    if (got !== 34'h0) $display("FAIL mul_zero: got %h want 0", got);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    logic ok;
    @(negedge clk);
    req_op = 4'd6; req_a = 16'h0003; req_b = 16'h01FF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 4'd0; req_a = 16'h0001; req_b = 16'h0001;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (rsp_lo !== 16'h07FF || lat !== 1)
      $display("FAIL ins_result: got lo=%h lat=%0d want lo=07ff lat=1", rsp_lo, lat);
    else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || req_ready || busy || rsp_lo !== 16'h07FF) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL stall_hold: got stable=%b want 1", ok);
    else n_pass++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if ({busy, req_ready} !== 2'b10)
      $display("FAIL held_accept: got busy=%b rdy=%b want 1 0", busy, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_lo} !== {1'b1, 16'h0002})
      $display("FAIL held_result: got vld=%b lo=%h want 1 0002", rsp_valid, rsp_lo);
    else n_pass++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [33:0] got; int lat; logic st; logic hs;
    run_op(4'd7, 16'hABCD, 16'h1234, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {32'h0, 1'b0, 1'b1} || lat !== 1)
      $display("FAIL illegal7: got %h lat=%0d want %h lat=1", got, lat, {32'h0, 1'b0, 1'b1});
    else n_pass++;
    run_op(4'd12, 16'hFFFF, 16'hFFFF, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {32'h0, 1'b0, 1'b1} || lat !== 1)
      $display("FAIL illegal12: got %h lat=%0d want %h lat=1", got, lat, {32'h0, 1'b0, 1'b1});
    else n_pass++;
    run_op(4'd0, 16'h0010, 16'h0020, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {16'h0, 16'h0030, 1'b0, 1'b0})
      $display("FAIL add_after_illegal: got %h want %h", got, {16'h0, 16'h0030, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    logic [33:0] got; int lat; logic st; logic hs;
    logic seen;
    @(negedge clk);
    req_op = 4'd8; req_a = 16'h1357; req_b = 16'h2468; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_carry, rsp_err, busy} !== {2'b10, 32'h0, 3'b000})
      $display("FAIL reset_mid_mul: got rdy=%b vld=%b lo=%h hi=%h c=%b e=%b busy=%b want rdy=1 rest 0",
               req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_carry, rsp_err, busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL dropped_op: got activity=%b want 0", seen);
    else n_pass++;
    run_op(4'd0, 16'h0002, 16'h0003, 0, got, lat, st, hs);
    n_checks++;
    if (got !== {16'h0, 16'h0005, 1'b0, 1'b0})
      $display("FAIL add_after_reset: got %h want %h", got, {16'h0, 16'h0005, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [33:0] got; logic [33:0] exp; int lat; logic st; logic hs;
    logic [3:0] op; logic [15:0] a; logic [15:0] b; int stall;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'd8;
      a  = 16'($urandom);
      b  = ((op == 4'd4 || op == 4'd5) && $urandom_range(0, 3) != 0)
           ? 16'($urandom_range(0, 17)) : 16'($urandom);
      stall = $urandom_range(0, 3);
      exp = model(op, a, b);
      run_op(op, a, b, stall, got, lat, st, hs);
      n_checks++;
      if (got !== exp || lat !== ((op == 4'd8) ? 16 : 1) || st !== 1'b1 || hs !== 1'b1)
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h lat=%0d st=%b hs=%b want %h lat=%0d st=1 hs=1",
                 i, op, a, b, got, lat, st, hs, exp, (op == 4'd8) ? 16 : 1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_shl();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
